display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//   Upstream scan controller for the 8-digit 3-to-8 active-low digit decoder.
//   Steps a 3-bit digit index at a prescaled refresh rate and drives it on sel[2:0] (decoder input w).
//   Presents the matching 4-bit nibble of a frame-buffered 32-bit display word.
//   Skips disabled digits and updates data only at frame boundaries, so digits never tear.
// PARAMETERS
//   PRESCALE     100000  clk cycles per digit slot; legal >=2
//   DEAD_CYCLES  16      blanking cycles after each digit advance (SCAN_BLANK_EN only); legal 1..PRESCALE-1
// PORTS
//   clk         in   1   system clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   en          in   1   scan enable; 0 freezes the scan and blanks the display
//   digit_en    in   8   per-digit enable mask, bit i = digit i
//   data        in   32  display word; nibble i = data[4i+3:4i] belongs to digit i
//   load        in   1   1-cycle strobe; captures data into the shadow register
//   sel         out  3   current digit index to the decoder
//   nibble      out  4   value for digit sel, from the active register
//   blank       out  1   1 = drive no digit / segments off
//   frame_done  out  1   1-cycle pulse on frame wrap
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - sel=0, nibble=0, blank=1, frame_done=0.
//     - Prescaler=0; shadow and active registers=0.
//   Data path:
//     - On load, shadow<=data.
//     - At a frame wrap: active<=(load ? data : shadow). Same-cycle load wins.
//     - nibble is registered: nibble = active[4*sel+:4], updated on the same edge as sel.
//   Prescaler:
//     - When en=1, counts 0..PRESCALE-1.
//     - The terminal count produces a tick and reloads 0.
//     - When en=0, holds its value. sel and nibble hold. blank=1 from the next edge.
//   Advance on tick:
//     - sel <= the lowest enabled index above sel, searching circularly (7 wraps to 0).
//     - Wrap: the new index <= the old index. A single enabled digit counts as a wrap on every tick.
//     - On a wrap, frame_done=1 for one cycle and the active register reloads.
//   Empty mask (digit_en==0):
//     - blank=1; sel holds; no frame_done.
//     - The prescaler keeps running.
//     - The first tick after any bit sets selects that digit as a normal advance.
//   Mask change mid-slot:
//     - If digit_en[sel] clears, blank=1 from the next edge until the next tick advances.
//   Blank:
//     - blank=0 only when en=1, digit_en[sel]=1, not in reset, and not in a dead window.
//   en rising: the scan resumes from the held sel and prescaler; no reset of state.
//   Reset mid-frame: state returns to reset values immediately. The first tick after release advances from sel=0.
//   Widths: prescaler counter is $clog2(PRESCALE) bits. The index search is combinational over the 8-bit mask.
// CONFIGURATION
//   SCAN_BLANK_EN defined:
//     - After every tick, blank=1 for DEAD_CYCLES cycles while sel/nibble already show the new digit.
//     - The dead window restarts on each tick and is cleared by reset.
//   SCAN_BLANK_EN undefined:
//     - No dead window; blank follows the blank rule above on the tick edge.
//     - DEAD_CYCLES is unused.
// TESTING (PRESCALE=4, DEAD_CYCLES=2)
//   1 Reset, en=1, digit_en=FF, load data=76543210 -> sel 0..7 every 4 clks; nibble==sel after the first wrap; frame_done every 32 clks.
//   2 digit_en=0x81 -> sel alternates 7,0; frame_done pulses each time sel goes 7->0; digits 1..6 never selected.
//   3 load 0xAAAAAAAA mid-frame -> nibble holds old values until the wrap, then shows A on all digits. Load on the wrap cycle -> new data used directly.
//   4 digit_en=0 -> blank=1, sel frozen, no frame_done. Set digit_en=0x10 -> sel=4 at the next tick, blank=0.
//   5 en=0 for 10 clks mid-slot -> sel/prescaler frozen, blank=1. Re-enable -> slot finishes its remaining count. Assert rst_n=0 mid-slot -> outputs at reset values with no clock edge.
//   6 SCAN_BLANK_EN defined -> blank=1 for exactly 2 clks after each tick, then 0. Undefined -> blank never rises with all digits enabled.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//   Scan controller feeding an 8-digit 3-to-8 active-low digit decoder.
//
//   The controller steps a 3-bit digit index at a prescaled refresh rate and
//   presents the matching nibble of a frame-buffered 32-bit display word. It
//   skips disabled digits. New display data takes effect only when the frame
//   wraps, so a digit never shows a mix of old and new data.
//
// Parameters
//   PRESCALE     clk cycles per digit slot (>= 2)
//   DEAD_CYCLES  blanking cycles after each digit advance (1..PRESCALE-1),
//                used only when SCAN_BLANK_EN is defined
//
// Configuration macro
//   SCAN_BLANK_EN  when defined, blank stays high for DEAD_CYCLES cycles after
//                  every tick. sel and nibble already show the new digit
//                  during that window.
//
// Ports
//   clk         in   1   system clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   en          in   1   scan enable; 0 freezes the scan and blanks the display
//   digit_en    in   8   per-digit enable mask, bit i = digit i
//   data        in   32  display word; nibble i belongs to digit i
//   load        in   1   strobe; captures data into the shadow register
//   sel         out  3   current digit index to the decoder
//   nibble      out  4   value for digit sel, from the active register
//   blank       out  1   1 = drive no digit / segments off
//   frame_done  out  1   1-cycle pulse on frame wrap
// -----------------------------------------------------------------------------
`default_nettype none

module display_scan_ctrl #(
  parameter int unsigned PRESCALE    = 100000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  digit_en,
  input  logic [31:0] data,
  input  logic        load,
  output logic [2:0]  sel,
  output logic [3:0]  nibble,
  output logic        blank,
  output logic        frame_done
);

  localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  // Elaboration-time rejection of illegal configurations
  if (PRESCALE < 2 || DEAD_CYCLES < 1 || DEAD_CYCLES >= PRESCALE) begin : g_bad_param
    $error("display_scan_ctrl: PRESCALE must be >= 2 and DEAD_CYCLES in 1..PRESCALE-1");
  end

  // State registers
  logic [PSC_W-1:0] r_psc;
  logic [2:0]       r_sel;
  logic [3:0]       r_nibble;
  logic             r_blank;
  logic             r_frame_done;
  logic [31:0]      r_shadow;
  logic [31:0]      r_active;

  // Next-state / decode wires
  logic             w_tick;
  logic [PSC_W-1:0] w_psc_nxt;
  logic             w_found;
  logic [2:0]       w_next_idx;
  logic             w_adv;
  logic             w_wrap;
  logic             w_frame;
  logic [2:0]       w_sel_nxt;
  logic [31:0]      w_active_nxt;
  logic             w_dead_active;
  logic             w_blank_nxt;

  // Prescaler next value and tick
  always_comb begin
    w_tick    = en && (r_psc == PSC_LAST);
    w_psc_nxt = r_psc;
    if (en) begin
      w_psc_nxt = w_tick ? '0 : r_psc + PSC_W'(1);
    end
  end

  // Circular search for the lowest enabled index above r_sel. Offset 8
  // aliases to r_sel itself, so a lone enabled digit finds itself as a wrap.
  always_comb begin
    w_found    = 1'b0;
    w_next_idx = r_sel;
    for (int k = 1; k <= 8; k++) begin
      if (!w_found && digit_en[3'(r_sel + 3'(k))]) begin
        w_found    = 1'b1;
        w_next_idx = 3'(r_sel + 3'(k));
      end
    end
  end

  // Advance, wrap detection and frame data selection
  always_comb begin
    w_adv        = w_tick && (digit_en != 8'h00);
    w_wrap       = (w_next_idx <= r_sel);
    w_frame      = w_adv && w_wrap;
    w_sel_nxt    = w_adv ? w_next_idx : r_sel;
    // A load on the wrap cycle bypasses the shadow register
    w_active_nxt = r_active;
    if (w_frame) begin
      w_active_nxt = load ? data : r_shadow;
    end
  end

`ifdef SCAN_BLANK_EN
  localparam int unsigned DEAD_W = $clog2(DEAD_CYCLES + 1);

  logic [DEAD_W-1:0] r_dead;
  logic [DEAD_W-1:0] w_dead_nxt;

  // Dead-window countdown, restarted by every tick
  always_comb begin
    w_dead_nxt = r_dead;
    if (w_tick) begin
      w_dead_nxt = DEAD_W'(DEAD_CYCLES);
    end else if (r_dead != '0) begin
      w_dead_nxt = r_dead - DEAD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dead <= '0;
    end else begin
      r_dead <= w_dead_nxt;
    end
  end

  assign w_dead_active = (w_dead_nxt != '0);
`else
  assign w_dead_active = 1'b0;
`endif

  // Blank is evaluated against the index that will be shown after this edge
  assign w_blank_nxt = !(en && digit_en[w_sel_nxt] && !w_dead_active);

  // Main state update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psc        <= '0;
      r_sel        <= 3'd0;
      r_nibble     <= 4'd0;
      r_blank      <= 1'b1;
      r_frame_done <= 1'b0;
      r_shadow     <= 32'd0;
      r_active     <= 32'd0;
    end else begin
      r_psc        <= w_psc_nxt;
      r_sel        <= w_sel_nxt;
      r_active     <= w_active_nxt;
      r_nibble     <= w_active_nxt[{w_sel_nxt, 2'b00} +: 4];
      r_blank      <= w_blank_nxt;
      r_frame_done <= w_frame;
      if (load) begin
        r_shadow <= data;
      end
    end
  end

  assign sel        = r_sel;
  assign nibble     = r_nibble;
  assign blank      = r_blank;
  assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//   Scoreboard bench for display_scan_ctrl (PRESCALE=4, DEAD_CYCLES=2).
//   The driver applies inputs on the falling edge and steps a behavioural
//   reference model. The model's expected outputs go into a queue. A
//   separate monitor pops the queue after each rising edge and compares the
//   DUT outputs against it.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

  localparam int unsigned P  = 4;
  localparam int unsigned DC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  digit_en;
  logic [31:0] data;
  logic        load;
  logic [2:0]  sel;
  logic [3:0]  nibble;
  logic        blank;
  logic        frame_done;

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] nib;
    logic       blank;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int          m_psc    = 0;
  int          m_sel    = 0;
  int          m_dead   = 0;
  logic [31:0] m_shadow = 32'd0;
  logic [31:0] m_active = 32'd0;
  exp_t        m_out;

  display_scan_ctrl #(.PRESCALE(P), .DEAD_CYCLES(DC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digit_en   (digit_en),
    .data       (data),
    .load       (load),
    .sel        (sel),
    .nibble     (nibble),
    .blank      (blank),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Model: outcome of the next rising edge given the currently driven inputs
  task automatic model_step();
    bit tick;
    int nxt;
    if (!rst_n) begin
      m_psc    = 0;
      m_sel    = 0;
      m_dead   = 0;
      m_shadow = 32'd0;
      m_active = 32'd0;
      m_out    = {3'd0, 4'd0, 1'b1, 1'b0};
      return;
    end
    tick     = en && (m_psc == int'(P) - 1);
    if (en) m_psc = (m_psc + 1) % int'(P);
    m_out.fd = 1'b0;
    if (tick && digit_en != 8'h00) begin
      nxt = -1;
      for (int d = 1; d <= 8; d++) begin
        if (nxt < 0 && digit_en[(m_sel + d) % 8]) nxt = (m_sel + d) % 8;
      end
      if (nxt <= m_sel) begin
        m_out.fd = 1'b1;
        m_active = load ? data : m_shadow;
      end
      m_sel = nxt;
    end
    if (load) m_shadow = data;
`ifdef SCAN_BLANK_EN
    if (tick) m_dead = int'(DC);
    else if (m_dead > 0) m_dead = m_dead - 1;
`endif
    m_out.sel   = 3'(m_sel);
    m_out.nib   = 4'((m_active >> (4 * m_sel)) & 32'hF);
    m_out.blank = !(en && digit_en[m_sel] && (m_dead == 0));
  endtask

  task automatic drive(input bit i_rst_n, input bit i_en, input logic [7:0] i_de,
                       input bit i_load, input logic [31:0] i_data);
    @(negedge clk);
    rst_n    = i_rst_n;
    en       = i_en;
    digit_en = i_de;
    load     = i_load;
    data     = i_data;
    model_step();
    q.push_back(m_out);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock edge
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sel, nibble, blank, frame_done} !== {3'd0, 4'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got sel=%0d nib=%h blank=%b fd=%b, want sel=0 nib=0 blank=1 fd=0",
               sel, nibble, blank, frame_done);
    end
    model_step();
    q.push_back(m_out);
  endtask

  // Monitor: compare every post-edge output sample with the next expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        exp_t a;
        e = q.pop_front();
        a = {sel, nibble, blank, frame_done};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs @%0t: got sel=%0d nib=%h blank=%b fd=%b, want sel=%0d nib=%h blank=%b fd=%b",
                   $time, a.sel, a.nib, a.blank, a.fd, e.sel, e.nib, e.blank, e.fd);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mask;
    bit         en_r;
    rst_n    = 1'b0;
    en       = 1'b0;
    digit_en = 8'h00;
    data     = 32'd0;
    load     = 1'b0;

    // Reset state, then full scan with the initial load
    repeat (3) drive(1'b0, 1'b0, 8'hFF, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 8'hFF, 1'b1, 32'h7654_3210);
    repeat (79) drive(1'b1, 1'b1, 8'hFF, 1'b0, $urandom);

    // Only digits 7 and 0 enabled
    repeat (40) drive(1'b1, 1'b1, 8'h81, 1'b0, $urandom);

    // Mid-frame load, then a load exactly on the wrap cycle
    repeat (9) drive(1'b1, 1'b1, 8'hFF, 1'b0, $urandom);
    drive(1'b1, 1'b1, 8'hFF, 1'b1, 32'hAAAA_AAAA);
    repeat (40) drive(1'b1, 1'b1, 8'hFF, 1'b0, $urandom);
    for (int i = 0; i < 64 && !(m_psc == int'(P) - 1 && m_sel == 7); i++)
      drive(1'b1, 1'b1, 8'hFF, 1'b0, $urandom);
    n_checks++;
    if (!(m_psc == int'(P) - 1 && m_sel == 7)) begin
      n_fail++;
      $display("FAIL wrap_search: got psc=%0d sel=%0d, want psc=%0d sel=7", m_psc, m_sel, P - 1);
    end
    drive(1'b1, 1'b1, 8'hFF, 1'b1, 32'h1357_9BDF);
    repeat (40) drive(1'b1, 1'b1, 8'hFF, 1'b0, $urandom);

    // Empty mask, then a single digit
    repeat (20) drive(1'b1, 1'b1, 8'h00, 1'b0, $urandom);
    repeat (20) drive(1'b1, 1'b1, 8'h10, 1'b0, $urandom);

    // Freeze mid-slot, resume, then asynchronous reset mid-slot
    repeat (6) drive(1'b1, 1'b1, 8'hFF, 1'b0, $urandom);
    repeat (10) drive(1'b1, 1'b0, 8'hFF, 1'b0, $urandom);
    repeat (21) drive(1'b1, 1'b1, 8'hFF, 1'b0, $urandom);
    async_reset();
    repeat (2) drive(1'b0, 1'b1, 8'hFF, 1'b0, $urandom);
    repeat (20) drive(1'b1, 1'b1, 8'hFF, 1'b0, $urandom);

    // Randomised mix of mask changes, enables, loads and resets
    mask = 8'hFF;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) begin
        case ($urandom_range(7))
          0:       mask = 8'h00;
          1:       mask = 8'hFF;
          default: mask = 8'($urandom);
        endcase
      end
      en_r = ($urandom_range(9) != 0);
      if ($urandom_range(199) == 0) begin
        async_reset();
      end else begin
        drive(1'b1, en_r, mask, ($urandom_range(5) == 0), $urandom);
      end
    end

    // Drain the scoreboard
    @(posedge clk);
    #3;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
